// File: rtl/sram_mbist_ctrl_if.sv
// rtl/sram_mbist_ctrl_if.sv - MBIST controller bundle: start/status, SRAM port and diagnostics
interface sram_mbist_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              start_i;
    logic              busy_o;
    logic              done_o;
    logic              fail_o;
    logic              mem_en_o;
    logic              w_en_o;
    logic [ADDR_W-1:0] w_addr_o;
    logic [DATA_W-1:0] w_data_o;
    logic              r_en_o;
    logic [ADDR_W-1:0] r_addr_o;
    logic [DATA_W-1:0] r_data_i;
    logic [ADDR_W-1:0] fail_addr_o;
    logic [DATA_W-1:0] fail_exp_o;
    logic [DATA_W-1:0] fail_act_o;
    logic [2:0]        fail_elem_o;

    modport master (
        input  start_i, r_data_i,
        output busy_o, done_o, fail_o, mem_en_o,
        output w_en_o, w_addr_o, w_data_o, r_en_o, r_addr_o,
        output fail_addr_o, fail_exp_o, fail_act_o, fail_elem_o
    );

    modport slave (
        output start_i, r_data_i,
        input  busy_o, done_o, fail_o, mem_en_o,
        input  w_en_o, w_addr_o, w_data_o, r_en_o, r_addr_o,
        input  fail_addr_o, fail_exp_o, fail_act_o, fail_elem_o
    );
endinterface

// File: rtl/sram_mbist_ctrl.sv
// rtl/sram_mbist_ctrl.sv - March C- MBIST controller; MBIST_DIAG_EN enables first-fail capture
module sram_mbist_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    sram_mbist_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
    localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] ONES      = '1;
    localparam logic [DATA_W-1:0] ZEROS     = '0;

    state_t            state, state_nxt;
    logic [2:0]        elem, elem_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic              wr_phase, wr_nxt;
    logic              w_en_q, w_en_nxt;
    logic              r_en_q, r_en_nxt;
    logic [DATA_W-1:0] w_data_q, w_data_nxt;
    logic [DATA_W-1:0] exp_q, exp_nxt;
    logic [2:0]        elem_inc;

    logic              cmp_vld;
    logic [DATA_W-1:0] cmp_exp;
    logic              fail_q;
    logic              start_acc;
    logic              miscompare;

    // Elements M3/M4 walk downwards; M1..M4 are read-then-write pairs.
    function automatic logic elem_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic logic elem_pair(input logic [2:0] e);
        return (e >= 3'd1) && (e <= 3'd4);
    endfunction

    assign start_acc  = (state == IDLE) && bus.start_i;
    assign miscompare = cmp_vld && (bus.r_data_i != cmp_exp);
    assign elem_inc   = elem + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            elem     <= 3'd0;
            addr     <= '0;
            wr_phase <= 1'b0;
            w_en_q   <= 1'b0;
            r_en_q   <= 1'b0;
            w_data_q <= '0;
            exp_q    <= '0;
            cmp_vld  <= 1'b0;
            cmp_exp  <= '0;
            fail_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            elem     <= elem_nxt;
            addr     <= addr_nxt;
            wr_phase <= wr_nxt;
            w_en_q   <= w_en_nxt;
            r_en_q   <= r_en_nxt;
            w_data_q <= w_data_nxt;
            exp_q    <= exp_nxt;
            cmp_vld  <= r_en_q;
            cmp_exp  <= exp_q;
            if (start_acc) begin
                fail_q <= 1'b0;
            end else if (miscompare) begin
                fail_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        elem_nxt   = elem;
        addr_nxt   = addr;
        wr_nxt     = wr_phase;
        w_en_nxt   = 1'b0;
        r_en_nxt   = 1'b0;
        w_data_nxt = w_data_q;
        exp_nxt    = exp_q;
        case (state)
            IDLE: begin
                if (bus.start_i) begin
                    state_nxt = RUN;
                    elem_nxt  = 3'd0;
                    addr_nxt  = '0;
                    wr_nxt    = 1'b1;
                end
            end
            RUN: begin
                if (elem_pair(elem) && !wr_phase) begin
                    wr_nxt = 1'b1;
                end else if (addr == (elem_down(elem) ? ADDR_ZERO : ADDR_MAX)) begin
                    if (elem == 3'd5) begin
                        state_nxt = DRAIN;
                    end else begin
                        // every element after M0 opens with a read
                        elem_nxt = elem_inc;
                        addr_nxt = elem_down(elem_inc) ? ADDR_MAX : ADDR_ZERO;
                        wr_nxt   = 1'b0;
                    end
                end else begin
                    addr_nxt = elem_down(elem) ? addr - ADDR_ONE : addr + ADDR_ONE;
                    wr_nxt   = (elem == 3'd0);
                end
            end
            DRAIN: state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == RUN) begin
            w_en_nxt   = wr_nxt;
            r_en_nxt   = !wr_nxt;
            w_data_nxt = ((elem_nxt == 3'd1) || (elem_nxt == 3'd3)) ? ONES : ZEROS;
            exp_nxt    = ((elem_nxt == 3'd2) || (elem_nxt == 3'd4)) ? ONES : ZEROS;
        end
    end

    assign bus.busy_o   = (state == RUN) || (state == DRAIN);
    assign bus.mem_en_o = bus.busy_o;
    assign bus.done_o   = (state == DONE);
    assign bus.fail_o   = fail_q;
    assign bus.w_en_o   = w_en_q;
    assign bus.r_en_o   = r_en_q;
    assign bus.w_addr_o = addr;
    assign bus.r_addr_o = addr;
    assign bus.w_data_o = w_data_q;

`ifdef MBIST_DIAG_EN
    logic [ADDR_W-1:0] cmp_addr;
    logic [2:0]        cmp_elem;
    logic [ADDR_W-1:0] diag_addr;
    logic [DATA_W-1:0] diag_exp;
    logic [DATA_W-1:0] diag_act;
    logic [2:0]        diag_elem;

    // Only the first miscompare of a run is kept; fail_q marks it already taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_addr  <= '0;
            cmp_elem  <= 3'd0;
            diag_addr <= '0;
            diag_exp  <= '0;
            diag_act  <= '0;
            diag_elem <= 3'd0;
        end else begin
            cmp_addr <= addr;
            cmp_elem <= elem;
            if (start_acc) begin
                diag_addr <= '0;
                diag_exp  <= '0;
                diag_act  <= '0;
                diag_elem <= 3'd0;
            end else if (miscompare && !fail_q) begin
                diag_addr <= cmp_addr;
                diag_exp  <= cmp_exp;
                diag_act  <= bus.r_data_i;
                diag_elem <= cmp_elem;
            end
        end
    end

    assign bus.fail_addr_o = diag_addr;
    assign bus.fail_exp_o  = diag_exp;
    assign bus.fail_act_o  = diag_act;
    assign bus.fail_elem_o = diag_elem;
`else
    assign bus.fail_addr_o = '0;
    assign bus.fail_exp_o  = '0;
    assign bus.fail_act_o  = '0;
    assign bus.fail_elem_o = 3'd0;
`endif

endmodule
